// File: rtl/game_fsm_ctrl.sv
// Snake game top-level sequencer: start, run, pause, death dwell, game-over
// dwell and restart. Lives are tracked here. A single hold counter times
// both the DIE and GAMEOVER dwells.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  INITIAL  | waiting for any direction press to start or resume play
//  RUNNING  | snake moving; a collision costs a life, a pause press pauses
//  PAUSED   | frozen; collisions and directions ignored until pause press
//  DIE      | death animation dwell of exactly DIE_HOLD cycles
//  GAMEOVER | no lives left; restart accepted once OVER_HOLD has elapsed
module game_fsm_ctrl #(
  parameter int unsigned DIE_HOLD  = 100_000_000,
  parameter int unsigned OVER_HOLD = 150_000_000,
  parameter int unsigned LIVES     = 3,
  parameter int unsigned PAUSE_EN  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       up,
  input  logic       down,
  input  logic       right,
  input  logic       left,
  input  logic       pause,
  input  logic       hit_boundary,
  input  logic       hit_self,
  output logic [2:0] game_state,
  output logic [3:0] lives_left,
  output logic       respawn,
  output logic       game_over
);

  localparam int unsigned CNT_MAX = (DIE_HOLD > OVER_HOLD) ? DIE_HOLD : OVER_HOLD;
  localparam int CW = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_RUNNING  = 3'd0,
    S_DIE      = 3'd1,
    S_INITIAL  = 3'd2,
    S_PAUSED   = 3'd3,
    S_GAMEOVER = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    lives_q, lives_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pause_q;
  logic          respawn_q, respawn_d;

  logic any_dir;
  logic pause_rise;
  logic collision;
  logic die_done;
  logic over_sat;

  assign any_dir    = up | down | left | right;
  assign pause_rise = pause & ~pause_q;
  assign collision  = hit_boundary | hit_self;
  assign die_done   = (cnt_q == CW'(DIE_HOLD - 1));
  assign over_sat   = (cnt_q == CW'(OVER_HOLD - 1));

  // State, lives, shared hold counter, pause edge history and respawn pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_INITIAL;
      lives_q   <= 4'(LIVES);
      cnt_q     <= '0;
      pause_q   <= 1'b0;
      respawn_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lives_q   <= lives_d;
      cnt_q     <= cnt_d;
      pause_q   <= pause;
      respawn_q <= respawn_d;
    end
  end

  // Next-state decode; collision beats pause in RUNNING, and the counter is
  // cleared on every dwell exit so it starts from zero on the next entry.
  always_comb begin
    state_d   = state_q;
    lives_d   = lives_q;
    cnt_d     = cnt_q;
    respawn_d = 1'b0;
    case (state_q)
      S_INITIAL: begin
        cnt_d = '0;
        if (any_dir) state_d = S_RUNNING;
      end
      S_RUNNING: begin
        if (collision) begin
          state_d = S_DIE;
          cnt_d   = '0;
          lives_d = (lives_q == 4'd0) ? 4'd0 : lives_q - 4'd1;
        end else if (pause_rise && (PAUSE_EN != 0)) begin
          state_d = S_PAUSED;
        end
      end
      S_PAUSED: begin
        if (pause_rise) state_d = S_RUNNING;
      end
      S_DIE: begin
        if (die_done) begin
          cnt_d = '0;
          if (lives_q == 4'd0) begin
            state_d = S_GAMEOVER;
          end else begin
            state_d   = S_INITIAL;
            respawn_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_GAMEOVER: begin
        if (over_sat) begin
          if (any_dir) begin
            state_d = S_INITIAL;
            lives_d = 4'(LIVES);
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_INITIAL;
        cnt_d   = '0;
      end
    endcase
  end

  assign game_state = state_q;
  assign lives_left = lives_q;
  assign respawn    = respawn_q;
  assign game_over  = (state_q == S_GAMEOVER);

endmodule

// File: tb/tb_game_fsm_ctrl.sv
// Directed bench for game_fsm_ctrl with short dwells. Stimulus pushes the
// expected post-edge outputs into a queue; a monitor pops and compares after
// every rising edge.
module tb_game_fsm_ctrl;

  localparam logic [2:0] RUN = 3'd0, DIE = 3'd1, INI = 3'd2, PAU = 3'd3, GOV = 3'd4;

  // Input vector bit positions: {rst, up, down, right, left, pause, hb, hs}
  localparam logic [7:0] N   = 8'b1000_0000;
  localparam logic [7:0] UP  = 8'b0100_0000;
  localparam logic [7:0] LF  = 8'b0000_1000;
  localparam logic [7:0] PS  = 8'b0000_0100;
  localparam logic [7:0] HB  = 8'b0000_0010;
  localparam logic [7:0] HS  = 8'b0000_0001;
  localparam logic [7:0] RST = 8'b0000_0000;

  logic       clk = 1'b0;
  logic       rst, up, down, right, left, pause, hit_boundary, hit_self;
  logic [2:0] game_state;
  logic [3:0] lives_left;
  logic       respawn, game_over;

  typedef struct packed {
    logic [2:0] st;
    logic [3:0] lv;
    logic       rs;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  game_fsm_ctrl #(
    .DIE_HOLD (4),
    .OVER_HOLD(3),
    .LIVES    (2),
    .PAUSE_EN (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .up          (up),
    .down        (down),
    .right       (right),
    .left        (left),
    .pause       (pause),
    .hit_boundary(hit_boundary),
    .hit_self    (hit_self),
    .game_state  (game_state),
    .lives_left  (lives_left),
    .respawn     (respawn),
    .game_over   (game_over)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs at the falling edge and queue the outputs
  // expected right after the following rising edge.
  task automatic step(input logic [7:0] v, input logic [2:0] st,
                      input logic [3:0] lv, input logic rs);
    exp_t e;
    @(negedge clk);
    {rst, up, down, right, left, pause, hit_boundary, hit_self} = v;
    e.st = st;
    e.lv = lv;
    e.rs = rs;
    exp_q.push_back(e);
  endtask

  // Monitor: compare every queued expectation just after the rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (game_state !== e.st) begin
        n_err++;
        $display("FAIL state cmp#%0d: got %0d want %0d", n_cmp, game_state, e.st);
      end
      n_cmp++;
      if (lives_left !== e.lv) begin
        n_err++;
        $display("FAIL lives cmp#%0d: got %0d want %0d", n_cmp, lives_left, e.lv);
      end
      n_cmp++;
      if (respawn !== e.rs) begin
        n_err++;
        $display("FAIL respawn cmp#%0d: got %0b want %0b", n_cmp, respawn, e.rs);
      end
      n_cmp++;
      if (game_over !== (e.st == GOV)) begin
        n_err++;
        $display("FAIL game_over cmp#%0d: got %0b want %0b", n_cmp, game_over, (e.st == GOV));
      end
    end
  end

  initial begin
    {rst, up, down, right, left, pause, hit_boundary, hit_self} = 8'h00;

    // Reset state
    step(RST, INI, 4'd2, 1'b0);
    step(RST, INI, 4'd2, 1'b0);
    step(N,   INI, 4'd2, 1'b0);

    // Start, then first death from hit_self
    step(N | UP, RUN, 4'd2, 1'b0);
    step(N,      RUN, 4'd2, 1'b0);
    step(N | HS, DIE, 4'd1, 1'b0);
    step(N,      DIE, 4'd1, 1'b0);
    step(N,      DIE, 4'd1, 1'b0);
    step(N,      DIE, 4'd1, 1'b0);
    step(N,      INI, 4'd1, 1'b1);
    step(N,      INI, 4'd1, 1'b0);

    // Pause held 3 cycles with collisions and directions during PAUSED
    step(N | UP,           RUN, 4'd1, 1'b0);
    step(N | PS,           PAU, 4'd1, 1'b0);
    step(N | PS | HB,      PAU, 4'd1, 1'b0);
    step(N | PS | HB | UP, PAU, 4'd1, 1'b0);
    step(N | HB,           PAU, 4'd1, 1'b0);
    step(N | PS,           RUN, 4'd1, 1'b0);
    step(N,                RUN, 4'd1, 1'b0);

    // Collision and pause rise together: DIE wins, last life lost
    step(N | PS | HB, DIE, 4'd0, 1'b0);
    step(N,           DIE, 4'd0, 1'b0);
    step(N,           DIE, 4'd0, 1'b0);
    step(N,           DIE, 4'd0, 1'b0);
    step(N,           GOV, 4'd0, 1'b0);

    // GAMEOVER: left on cycles 1-2 ignored, accepted on cycle 3
    step(N | LF, GOV, 4'd0, 1'b0);
    step(N | LF, GOV, 4'd0, 1'b0);
    step(N | LF, INI, 4'd2, 1'b0);
    step(N,      INI, 4'd2, 1'b0);

    // Reset mid-DIE abandons the count; up held through reset starts at once
    step(N | UP, RUN, 4'd2, 1'b0);
    step(N | HS, DIE, 4'd1, 1'b0);
    step(N,      DIE, 4'd1, 1'b0);
    step(RST,      INI, 4'd2, 1'b0);
    step(RST | UP, INI, 4'd2, 1'b0);
    step(N | UP,   RUN, 4'd2, 1'b0);
    step(N | HB,   DIE, 4'd1, 1'b0);
    step(N,        DIE, 4'd1, 1'b0);
    step(N,        DIE, 4'd1, 1'b0);
    step(N,        DIE, 4'd1, 1'b0);
    step(N,        INI, 4'd1, 1'b1);
    step(N,        INI, 4'd1, 1'b0);

    // Let the monitor drain, bounded
    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
